mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the pipeline memory stage. It turns load/store requests from EX/MEM into a request/acknowledge transaction on the data bus, stalling the pipeline until the access completes. It places store data on little-endian byte lanes with byte enables, and extracts and sign- or zero-extends load data. It flags misaligned accesses and bus timeouts, and selects the write-back value among the load result, the ALU result and the LUI immediate.

Parameters:
ADDR_W, 32, byte-address width; bus_addr is a word address of ADDR_W-2 bits.
TIMEOUT, 16, number of BUSY cycles without bus_ack before the access aborts; legal range 2..255.
HOLD_STALL_ON_ERR, 0, if 1 then stall also stays high during the abort cycle of a timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  load request, held stable while stall=1
mem_write  in  1  store request, held stable while stall=1
mem_size  in  2  00 none, 01 byte, 10 half, 11 word
load_unsigned  in  1  1 = zero-extend byte/half loads, 0 = sign-extend
alu_result  in  ADDR_W  effective address / ALU write-back value
din  in  32  store data (right-aligned)
imme  in  16  LUI immediate
mem_to_reg  in  1  write-back selects load data
lui_sig  in  1  write-back selects {imme,16'h0}
stall  out  1  freeze upstream pipeline
dout  out  32  write-back data
misalign  out  1  combinational misaligned-access flag
bus_err  out  1  one-cycle timeout pulse
bus_req  out  1  registered transaction request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W-2  alu_result[ADDR_W-1:2]
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  completion, sampled on clk
bus_rdata  in  32  read data, valid when bus_ack=1

Behaviour:
- Reset values: state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, bus_err=0, hold register=0, timeout counter=0.
- While rst=1, stall=0 and dout=0 (combinational override).
- access = (mem_read|mem_write) & mem_size!=00 & !misalign.
- misalign is high for: half with alu_result[0]=1; word with alu_result[1:0]!=0. A misaligned access issues no bus cycle and no stall; the load result is 0.
- State machine:
  - IDLE: if access, then stall=1 combinationally and next state is BUSY. At that edge, register bus_req=1, bus_we, bus_addr, bus_be, bus_wdata, and clear the counter.
  - BUSY: stall=1. The counter increments each cycle.
    - If bus_ack: capture bus_rdata into the hold register, bus_req<=0, go to DONE.
    - Else if counter==TIMEOUT-1: bus_req<=0, bus_err<=1 for one cycle, hold<=0, go to DONE.
    - If bus_ack and the timeout coincide, the ack wins and bus_err stays 0.
  - DONE: stall=0 (or 1 if a timeout occurred and HOLD_STALL_ON_ERR=1). dout uses the hold register. Always go to IDLE next; no new access is accepted in DONE.
- Minimum latency is 3 cycles: present, ack in the first BUSY cycle, DONE.
- bus_be / bus_wdata, with k=alu_result[1:0]:
  - byte: be=1<<k, wdata={4{din[7:0]}}.
  - half: be=0011 if k[1]=0, else 1100; wdata={2{din[15:0]}}.
  - word: be=1111, wdata=din.
  - Reads drive be with the same pattern.
- Load extract from the hold register, little-endian:
  - byte lane k: bits [8k+7:8k].
  - half: k[1]=0 gives [15:0], k[1]=1 gives [31:16].
  - Extend per load_unsigned.
- dout priority: lui_sig → {imme,16'h0}; else mem_to_reg → load result; else alu_result[31:0], zero-extended if ADDR_W<32.
- bus_ack outside BUSY is ignored.
- bus_addr, bus_we, bus_be and bus_wdata stay stable while bus_req=1.
- Reset asserted mid-BUSY: next edge returns to IDLE and bus_req=0. A late bus_ack after reset is ignored.

Test Plan:
1. Word load at 0x100, bus_ack on the 2nd BUSY cycle with rdata 0xDEADBEEF, mem_to_reg=1 → stall high 3 cycles, bus_addr=0x40, be=1111, dout=0xDEADBEEF in DONE.
2. Signed byte load at 0x103, rdata 0x80112233 → be=1000, dout=0xFFFFFF80. Same with load_unsigned=1 → dout=0x00000080.
3. Half store at 0x206, din=0x0000A5C3 → bus_we=1, be=1100, wdata=0xA5C3A5C3, bus_addr=0x81, stall drops in DONE.
4. Word load at 0x102 → misalign=1, bus_req stays 0, stall=0, dout=0.
5. TIMEOUT=16, no ack → bus_req high exactly 16 cycles, then one bus_err pulse, dout=0, then IDLE. Repeat with ack on the 16th cycle → no bus_err.
6. rst asserted in the 3rd BUSY cycle, then an ack arrives → IDLE, bus_req=0, stall=0, no capture. lui_sig=1, imme=0x1234 → dout=0x12340000 regardless of mem_to_reg.

Source files
------------

// File: rtl/mem_bus_if.sv
// Data-bus request/acknowledge bundle between the memory stage
// and the data memory.
interface mem_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-3:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: load/store over a req/ack data bus with
// byte-lane steering, load extension, timeout and write-back select.
module mem_access_unit #(
  parameter int ADDR_W            = 32,
  parameter int TIMEOUT           = 16,
  parameter int HOLD_STALL_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_mem_size,
  input  logic              i_load_unsigned,
  input  logic [ADDR_W-1:0] i_alu_result,
  input  logic [31:0]       i_din,
  input  logic [15:0]       i_imme,
  input  logic              i_mem_to_reg,
  input  logic              i_lui_sig,
  output logic              o_stall,
  output logic [31:0]       o_dout,
  output logic              o_misalign,
  output logic              o_bus_err,
  mem_bus_if.master         bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_hold;
  logic        r_err;

  logic [1:0]  w_k;
  logic        w_req_any;
  logic        w_misalign;
  logic        w_access;
  logic        w_timeout;
  logic        w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_alu32;
  logic [31:0] w_wb;

  assign w_k       = i_alu_result[1:0];
  assign w_req_any = i_mem_read | i_mem_write;

  assign w_misalign = w_req_any &
    (((i_mem_size == 2'b10) & w_k[0]) |
     ((i_mem_size == 2'b11) & (w_k != 2'b00)));

  assign w_access = w_req_any & (i_mem_size != 2'b00) &
                    !w_misalign;

  assign w_timeout = (r_state == S_BUSY) & !bus.bus_ack &
                     (r_cnt == LP_TO_LAST);

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    unique case (i_mem_size)
      2'b01: begin
        w_be    = 4'b0001 << w_k;
        w_wdata = {4{i_din[7:0]}};
      end
      2'b10: begin
        w_be    = w_k[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_din[15:0]}};
      end
      2'b11: begin
        w_be    = 4'b1111;
        w_wdata = i_din;
      end
      default: ;
    endcase
  end

  // Little-endian lane pick from the captured read word
  assign w_byte = r_hold[{w_k, 3'b000} +: 8];
  assign w_half = w_k[1] ? r_hold[31:16] : r_hold[15:0];

  always_comb begin
    w_load = 32'h0;
    unique case (i_mem_size)
      2'b01: w_load = {{24{!i_load_unsigned & w_byte[7]}},
                       w_byte};
      2'b10: w_load = {{16{!i_load_unsigned & w_half[15]}},
                       w_half};
      2'b11: w_load = r_hold;
      default: ;
    endcase
    if (w_misalign) w_load = 32'h0;
  end

  assign w_alu32 = 32'(i_alu_result);

  always_comb begin
    w_wb = w_alu32;
    if (i_lui_sig)         w_wb = {i_imme, 16'h0};
    else if (i_mem_to_reg) w_wb = w_load;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_stall = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (bus.bus_ack | w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        w_stall = (HOLD_STALL_ON_ERR != 0) & r_err;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'h0;
      r_err         <= 1'b0;
      r_hold        <= 32'h0;
      r_cnt         <= 8'h0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_IDLE && w_access) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= i_mem_write;
        bus.bus_addr  <= i_alu_result[ADDR_W-1:2];
        bus.bus_be    <= w_be;
        bus.bus_wdata <= w_wdata;
        r_cnt         <= 8'h0;
      end
      if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
        // Ack takes precedence over a coincident timeout
        if (bus.bus_ack) begin
          r_hold      <= bus.bus_rdata;
          bus.bus_req <= 1'b0;
        end else if (w_timeout) begin
          r_hold      <= 32'h0;
          bus.bus_req <= 1'b0;
          r_err       <= 1'b1;
        end
      end
    end
  end

  assign o_misalign = w_misalign;
  assign o_bus_err  = r_err;
  assign o_stall    = !rst & w_stall;
  assign o_dout     = rst ? 32'h0 : w_wb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random checks of mem_access_unit against a
// transaction-level model of the memory stage.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] alu_result;
  logic [31:0] din;
  logic [15:0] imme;
  logic        mem_to_reg, lui_sig;
  logic        stall, misalign, bus_err;
  logic [31:0] dout;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hold   = 32'h0;

  mem_bus_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(
    .ADDR_W(32), .TIMEOUT(16), .HOLD_STALL_ON_ERR(0)
  ) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_size(mem_size), .i_load_unsigned(load_unsigned),
    .i_alu_result(alu_result), .i_din(din), .i_imme(imme),
    .i_mem_to_reg(mem_to_reg), .i_lui_sig(lui_sig),
    .o_stall(stall), .o_dout(dout), .o_misalign(misalign),
    .o_bus_err(bus_err), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic f_mis(input logic [1:0] sz,
                                 input logic [1:0] k);
    return (sz == 2 && k % 2 == 1) || (sz == 3 && k != 0);
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz,
                                      input logic [1:0] k);
    case (sz)
      2'd1: return 4'(2 ** int'(k));
      2'd2: return (k >= 2) ? 4'hC : 4'h3;
      2'd3: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz,
                                          input logic [31:0] d);
    case (sz)
      2'd1: return (d & 32'hFF) * 32'h0101_0101;
      2'd2: return (d & 32'hFFFF) * 32'h0001_0001;
      2'd3: return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] h,
      input logic [1:0] sz, input logic [1:0] k, input logic u);
    logic [31:0] v;
    case (sz)
      2'd1: begin
        v = (h >> (8 * k)) & 32'hFF;
        if (!u && v >= 128) v = v | 32'hFFFF_FF00;
      end
      2'd2: begin
        v = (h >> (16 * (k / 2))) & 32'hFFFF;
        if (!u && v >= 32768) v = v | 32'hFFFF_0000;
      end
      2'd3: v = h;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; mem_size = 0;
    load_unsigned = 0; mem_to_reg = 0; lui_sig = 0;
  endtask

  // ack_at: BUSY cycle (1..16) that carries bus_ack, 0 = never
  task automatic access(input bit rd, input bit wr,
      input logic [1:0] sz, input bit u, input logic [31:0] a,
      input logic [31:0] d, input int ack_at,
      input logic [31:0] rdata, input string tag);
    int  reqs, stalls, nb;
    bit  mis, tmo;
    reqs = 0; stalls = 0; nb = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_size = sz;
    load_unsigned = u; alu_result = a; din = d;
    mem_to_reg = rd; lui_sig = 0;
    mis = f_mis(sz, a[1:0]);
    @(negedge clk);
    chk({tag, "/misalign"}, 32'(misalign), 32'(mis));
    if (mis) begin
      chk({tag, "/mis_stall"}, 32'(stall), 0);
      chk({tag, "/mis_dout"}, dout, rd ? 32'h0 : a);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk({tag, "/mis_req"}, 32'(bus.bus_req), 0);
      return;
    end
    chk({tag, "/idle_stall"}, 32'(stall), 1);
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      nb = n;
      reqs += int'(bus.bus_req);
      stalls += int'(stall);
      chk({tag, "/addr"}, 32'(bus.bus_addr), {2'b00, a[31:2]});
      chk({tag, "/we"}, 32'(bus.bus_we), 32'(wr));
      chk({tag, "/be"}, 32'(bus.bus_be), 32'(f_be(sz, a[1:0])));
      chk({tag, "/wdata"}, bus.bus_wdata, f_wdata(sz, d));
      if (n == ack_at) begin
        bus.bus_ack = 1; bus.bus_rdata = rdata;
      end
      @(posedge clk); #1;
      bus.bus_ack = 0;
      if (n == ack_at) break;
    end
    tmo = (ack_at < 1 || ack_at > 16);
    m_hold = tmo ? 32'h0 : rdata;
    chk({tag, "/busy_cycles"}, 32'(nb), tmo ? 16 : ack_at);
    chk({tag, "/req_cycles"}, 32'(reqs), 32'(nb));
    chk({tag, "/stall_cycles"}, 32'(stalls), 32'(nb));
    @(negedge clk);
    chk({tag, "/done_req"}, 32'(bus.bus_req), 0);
    chk({tag, "/done_err"}, 32'(bus_err), 32'(tmo));
    chk({tag, "/done_stall"}, 32'(stall), 0);
    chk({tag, "/done_dout"}, dout,
        rd ? f_load(m_hold, sz, a[1:0], u) : a);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk({tag, "/idle_err"}, 32'(bus_err), 0);
    chk({tag, "/idle_stall2"}, 32'(stall), 0);
    chk({tag, "/idle_req"}, 32'(bus.bus_req), 0);
  endtask

  initial begin
    logic [31:0] ra, rd_data, rdin;
    logic [1:0]  rsz;
    bit          rrd;
    int          rack;
    rst = 1; clear_inputs();
    alu_result = 0; din = 0; imme = 0;
    bus.bus_ack = 0; bus.bus_rdata = 0;
    mem_read = 1; mem_size = 2'b11;
    lui_sig = 1; imme = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/req", 32'(bus.bus_req), 0);
    chk("rst/be", 32'(bus.bus_be), 0);
    chk("rst/wdata", bus.bus_wdata, 0);
    chk("rst/addr", 32'(bus.bus_addr), 0);
    chk("rst/err", 32'(bus_err), 0);
    chk("rst/stall", 32'(stall), 0);
    chk("rst/dout", dout, 0);
    @(posedge clk); #1;
    rst = 0; clear_inputs(); imme = 0;

    access(1, 0, 2'd3, 0, 32'h100, 0, 2, 32'hDEADBEEF, "t1");
    access(1, 0, 2'd1, 0, 32'h103, 0, 1, 32'h80112233, "t2s");
    access(1, 0, 2'd1, 1, 32'h103, 0, 1, 32'h80112233, "t2u");
    access(0, 1, 2'd2, 0, 32'h206, 32'h0000A5C3, 1,
           32'h0, "t3");
    access(1, 0, 2'd3, 0, 32'h102, 0, 1, 32'h0, "t4");
    access(1, 0, 2'd3, 0, 32'h300, 0, 0, 32'h1111, "t5to");
    access(1, 0, 2'd2, 0, 32'h302, 0, 16, 32'hBEEF1234, "t5ack");

    // ack outside BUSY must not touch the hold register
    @(posedge clk); #1;
    mem_size = 2'b11; mem_to_reg = 1;
    bus.bus_ack = 1; bus.bus_rdata = 32'h55AA_55AA;
    @(negedge clk);
    chk("idle_ack/req", 32'(bus.bus_req), 0);
    chk("idle_ack/stall", 32'(stall), 0);
    @(posedge clk); #1;
    bus.bus_ack = 0;
    @(negedge clk);
    chk("idle_ack/dout", dout, m_hold);

    // reset during the third BUSY cycle, then a late ack
    @(posedge clk); #1;
    mem_read = 1; mem_size = 2'b11; mem_to_reg = 1;
    alu_result = 32'h400;
    repeat (3) @(posedge clk);
    #1; rst = 1;
    @(negedge clk);
    chk("rst6/stall", 32'(stall), 0);
    chk("rst6/dout", dout, 0);
    @(posedge clk); #1;
    rst = 0; clear_inputs();
    bus.bus_ack = 1; bus.bus_rdata = 32'hCAFEF00D;
    m_hold = 32'h0;
    @(negedge clk);
    chk("rst6/req", 32'(bus.bus_req), 0);
    chk("rst6/stall2", 32'(stall), 0);
    @(posedge clk); #1;
    bus.bus_ack = 0; mem_size = 2'b11; mem_to_reg = 1;
    @(negedge clk);
    chk("rst6/nocapture", dout, m_hold);

    @(posedge clk); #1;
    lui_sig = 1; imme = 16'h1234; mem_to_reg = 1;
    @(negedge clk);
    chk("lui/m2r1", dout, 32'h12340000);
    @(posedge clk); #1;
    mem_to_reg = 0; alu_result = 32'h7777;
    @(negedge clk);
    chk("lui/m2r0", dout, 32'h12340000);
    @(posedge clk); #1;
    clear_inputs();

    for (int i = 0; i < 24; i++) begin
      ra      = $urandom;
      rdin    = $urandom;
      rd_data = $urandom;
      rsz     = 2'($urandom_range(1, 3));
      rrd     = 1'($urandom_range(0, 1));
      rack    = ($urandom_range(0, 7) == 0) ? 0
              : $urandom_range(1, 5);
      access(rrd, !rrd, rsz, 1'($urandom_range(0, 1)), ra,
             rdin, rack, rd_data, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
